uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver, the stage downstream of the core's UART transmitter. It turns the serial `tx` line into bytes with a valid/ready handshake. Uses:
- host-side loopback in the system bench;
- future command/program-load path into the core.

Sampling is 16x oversampled with majority vote. It flags framing errors and overruns.

Parameters:
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- TICK_DIV, CLK_FREQ/(BAUD*16): clocks per oversample tick (derived localparam, integer division, must be >=1; elaborate-time error otherwise).

Ports:
- clk  input  1  system clock (PLL output).
- areset  input  1  asynchronous, active-low reset; all state cleared while low.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  received byte; stable while data_valid=1.
- data_valid  output  1  byte available in holding register.
- data_ready  input  1  consumer accepts byte when data_valid&&data_ready at a rising clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because holding register full.

Behaviour:
- Reset values:
  - data_out=8'h00, data_valid=0, frame_err=0, overrun=0;
  - synchronizer flops=1, FSM=IDLE, tick counter=0, sample counter=0.
- Input path:
  - 2-flop synchronizer on rx; all logic uses the synchronized value rxs.
  - 2-cycle input latency.
- Tick generator:
  - counter 0..TICK_DIV-1; tick=1 for one clk when counter wraps.
  - Cleared on entry to START so bit phase aligns to the falling edge.
- Sample counter s:
  - 0..15, advances on tick, wraps 15->0 = one bit period.
  - Samples taken at s=7,8,9; vote = majority of the three.
- FSM:
  - IDLE: rxs==0 -> START (s=0, tick counter cleared).
  - START: at s=9 evaluate vote. vote==1 -> IDLE (glitch rejected, no flag). vote==0 -> DATA at end of bit (s=15 wrap), bit index=0.
  - DATA: at s=9 shift vote into shift register, LSB first. After bit index 7 wraps -> STOP.
  - STOP: at s=9 evaluate vote.
    - vote==1: byte good -> IDLE immediately (half-bit early, tolerates clock skew).
    - vote==0: frame_err pulse, byte discarded -> BREAK.
  - BREAK: wait until rxs==1, then -> IDLE. Prevents a held-low line (break) from generating bytes.
- Holding register, on a good byte (the cycle after the STOP s=9 decision):
  - data_valid==0, or data_valid&&data_ready in the same cycle: load data_out, data_valid=1.
  - Otherwise: overrun pulses one cycle; new byte dropped; data_out/data_valid unchanged.
- data_valid&&data_ready with no new byte: data_valid->0. data_out holds its last value.
- Latency: data_valid rises 1 clk after the stop-bit s=9 tick.
- frame_err and overrun are mutually exclusive per frame. Each is exactly one clk wide.
- areset deassert mid-frame: receiver restarts in IDLE. A partially received frame is never reported.
- rx low at reset release: treated as a new start edge after synchronizer latency.

Decomposition:
- uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - OVERSAMPLE=16;
  - sample indices SAMP_A=7, SAMP_B=8, SAMP_C=9;
  - DATA_BITS=8.
- One sub-module: uart_baud_tick. Parameters TICK_DIV; ports clk, areset, clr, tick. Reusable by the transmitter.
- FSM, shift register and holding register stay in uart_rx.

Test Plan (CLK_FREQ=1_600_000, BAUD=100_000 -> TICK_DIV=1, 16 clk/bit):
- Send 0xA5 (frame 0,1,0,1,0,0,1,0,1,1) with data_ready=0 -> data_valid=1, data_out=8'hA5, no flags. Then data_ready=1 for one clk -> data_valid=0.
- Pulse rx low for 4 clk, then high -> FSM returns to IDLE, no data_valid, no frame_err.
- Send 0x3C with stop bit forced 0, hold rx low 40 clk, then high -> one frame_err pulse, no data_valid. Next frame 0x81 is received correctly.
- data_ready=0; send 0x11 then 0x22 back-to-back -> data_out=8'h11, overrun pulses once at the 0x22 stop decision. After ready: data_valid=0, no 0x22.
- data_ready=1 constantly; send 0x00 then 0xFF back-to-back -> two data_valid one-cycle pulses with data_out 8'h00 then 8'hFF, no flags.
- Assert areset=0 at data bit 4 of 0x5A for 3 clk, then release with the line idle -> all outputs at reset values, no byte reported. Next frame 0xC3 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and the
// sample-vote helper.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SCNT_W     = $clog2(OVERSAMPLE);
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned IDX_W      = $clog2(DATA_BITS);

    // Mid-bit sample points; the vote is resolved on the last of the three
    localparam logic [SCNT_W-1:0] SAMP_A = SCNT_W'(7);
    localparam logic [SCNT_W-1:0] SAMP_B = SCNT_W'(8);
    localparam logic [SCNT_W-1:0] SAMP_C = SCNT_W'(9);
    localparam logic [SCNT_W-1:0] S_LAST = SCNT_W'(OVERSAMPLE - 1);

    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every TICK_DIV clocks, restartable
// so the bit phase can be aligned to an incoming edge.
module uart_baud_tick #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic areset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A clear restarts the phase, so it must not also emit a tick
    assign tick = w_wrap && !clr;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling with 3-sample majority vote, framing
// error and overrun reporting, single-entry holding register with valid/ready.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("uart_rx: CLK_FREQ too low for BAUD with 16x oversampling");
    end

    logic r_sync1;
    logic r_sync2;
    logic w_rxs;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    logic w_tick;
    logic w_clr;

    uart_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_baud_tick (
        .clk    (clk),
        .areset (areset),
        .clr    (w_clr),
        .tick   (w_tick)
    );

    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic [SCNT_W-1:0]    r_s;
    logic [SCNT_W-1:0]    w_s_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [1:0]           r_samp;
    logic                 w_vote;
    logic                 w_good;
    logic                 w_ferr;

    assign w_vote = maj3(r_samp[0], r_samp[1], w_rxs);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state <= StIdle;
            r_s     <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_samp  <= 2'b11;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            if (w_tick && (r_s == SAMP_A)) begin
                r_samp[0] <= w_rxs;
            end
            if (w_tick && (r_s == SAMP_B)) begin
                r_samp[1] <= w_rxs;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_clr       = 1'b0;
        w_good      = 1'b0;
        w_ferr      = 1'b0;

        if (w_tick) begin
            w_s_nxt = r_s + SCNT_W'(1);
        end

        unique case (r_state)
            StIdle: begin
                w_s_nxt = '0;
                if (!w_rxs) begin
                    w_state_nxt = StStart;
                    w_clr       = 1'b1;
                end
            end
            StStart: begin
                if (w_tick) begin
                    if ((r_s == SAMP_C) && w_vote) begin
                        w_state_nxt = StIdle;
                    end else if (r_s == S_LAST) begin
                        w_state_nxt = StData;
                        w_idx_nxt   = '0;
                    end
                end
            end
            StData: begin
                if (w_tick) begin
                    if (r_s == SAMP_C) begin
                        w_shift_nxt = {w_vote, r_shift[DATA_BITS-1:1]};
                    end
                    if (r_s == S_LAST) begin
                        if (r_idx == LAST_BIT) begin
                            w_state_nxt = StStop;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end
                end
            end
            StStop: begin
                // Leave half a bit early so a slightly fast sender is tolerated
                if (w_tick && (r_s == SAMP_C)) begin
                    if (w_vote) begin
                        w_state_nxt = StIdle;
                        w_good      = 1'b1;
                    end else begin
                        w_state_nxt = StBreak;
                        w_ferr      = 1'b1;
                    end
                end
            end
            StBreak: begin
                if (w_rxs) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (w_good) begin
                if (!r_valid || data_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit (TICK_DIV=1).
module tb_uart_rx;

    logic       clk;
    logic       areset;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLK_FREQ (1_600_000),
        .BAUD     (100_000)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Monitor: cycles each flag is high, and data_out captured at each rise of data_valid
    int         n_ferr = 0;
    int         n_ovr  = 0;
    int         n_vhi  = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] cap[$];

    always @(negedge clk) begin
        if (frame_err) n_ferr <= n_ferr + 1;
        if (overrun) n_ovr <= n_ovr + 1;
        if (data_valid) n_vhi <= n_vhi + 1;
        if (data_valid && !prev_valid) cap.push_back(data_out);
        prev_valid <= data_valid;
    end

    int b_ferr;
    int b_ovr;
    int b_vhi;
    int b_cap;

    task automatic snap();
        b_ferr = n_ferr;
        b_ovr  = n_ovr;
        b_vhi  = n_vhi;
        b_cap  = cap.size();
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        cycles(16);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    task automatic check_byte(input string name, input int idx, input logic [7:0] exp);
        if (cap.size() > idx) check(name, int'(cap[idx]), int'(exp));
        else check(name, -1, int'(exp));
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_rise;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{data: 8'h00, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
        vecs[2] = '{data: 8'h55, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'h96, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
        vecs[4] = '{data: 8'h3C, stop: 1'b0, exp_rise: 0, exp_ferr: 1};

        areset     = 1'b0;
        rx         = 1'b1;
        data_ready = 1'b0;
        cycles(3);
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        areset = 1'b1;
        cycles(20);

        data_ready = 1'b1;
        foreach (vecs[k]) begin
            snap();
            send_frame(vecs[k].data, vecs[k].stop);
            rx = 1'b1;
            cycles(40);
            check($sformatf("vec%0d_rises", k), cap.size() - b_cap, vecs[k].exp_rise);
            check($sformatf("vec%0d_ferr", k), n_ferr - b_ferr, vecs[k].exp_ferr);
            check($sformatf("vec%0d_ovr", k), n_ovr - b_ovr, 0);
            if (vecs[k].exp_rise == 1) check_byte($sformatf("vec%0d_data", k), b_cap, vecs[k].data);
        end

        // Byte held until accepted
        data_ready = 1'b0;
        snap();
        send_frame(8'hA5, 1'b1);
        cycles(4);
        check("a5_valid", int'(data_valid), 1);
        check("a5_data", int'(data_out), 8'hA5);
        check("a5_flags", (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
        data_ready = 1'b1;
        cycles(1);
        data_ready = 1'b0;
        check("a5_accepted", int'(data_valid), 0);
        check("a5_held_out", int'(data_out), 8'hA5);

        // Short low glitch rejected
        snap();
        rx = 1'b0;
        cycles(4);
        rx = 1'b1;
        cycles(40);
        check("glitch_rises", cap.size() - b_cap, 0);
        check("glitch_ferr", n_ferr - b_ferr, 0);

        // Framing error followed by line break, then recovery
        data_ready = 1'b1;
        snap();
        send_frame(8'h3C, 1'b0);
        cycles(40);
        rx = 1'b1;
        cycles(20);
        check("brk_ferr_cycles", n_ferr - b_ferr, 1);
        check("brk_rises", cap.size() - b_cap, 0);
        snap();
        send_frame(8'h81, 1'b1);
        cycles(10);
        check("after_brk_rises", cap.size() - b_cap, 1);
        check_byte("after_brk_data", b_cap, 8'h81);
        check("after_brk_ferr", n_ferr - b_ferr, 0);

        // Overrun: second byte dropped while first still held
        data_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rx = 1'b1;
        cycles(10);
        check("ovr_cycles", n_ovr - b_ovr, 1);
        check("ovr_ferr", n_ferr - b_ferr, 0);
        check("ovr_valid", int'(data_valid), 1);
        check("ovr_data", int'(data_out), 8'h11);
        data_ready = 1'b1;
        cycles(1);
        data_ready = 1'b0;
        cycles(40);
        check("ovr_drained", int'(data_valid), 0);
        check("ovr_rises", cap.size() - b_cap, 1);

        // Back-to-back with ready held: two single-cycle valid pulses
        data_ready = 1'b1;
        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        rx = 1'b1;
        cycles(20);
        check("b2b_rises", cap.size() - b_cap, 2);
        check_byte("b2b_first", b_cap, 8'h00);
        check_byte("b2b_second", b_cap + 1, 8'hFF);
        check("b2b_valid_cycles", n_vhi - b_vhi, 2);
        check("b2b_flags", (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);

        // Reset in the middle of data bit 4
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(8'h5A >> i);
        rx = 1'b1;
        cycles(8);
        areset = 1'b0;
        #1;
        check("mid_rst_data_out", int'(data_out), 0);
        check("mid_rst_valid", int'(data_valid), 0);
        cycles(3);
        areset = 1'b1;
        cycles(200);
        check("mid_rst_rises", cap.size() - b_cap, 0);
        check("mid_rst_flags", (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
        snap();
        send_frame(8'hC3, 1'b1);
        rx = 1'b1;
        cycles(10);
        check("post_rst_rises", cap.size() - b_cap, 1);
        check_byte("post_rst_data", b_cap, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
